if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk_i  input  1  rising-edge clock, single clock domain.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 start_i  input  1  leave IDLE and begin fetching; sampled only in IDLE.
REQ-005 stall_i  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-006 branch_i  input  1  taken beq from decode (branch_o qualified by register equality).
REQ-007 branch_target_i  input  32  branch destination.
REQ-008 jump_i  input  1  jump from decode (PC_i_mux_o).
REQ-009 jump_target_i  input  32  jump destination.
REQ-010 imem_req_o  output  1  instruction fetch request.
REQ-011 imem_addr_o  output  32  fetch address, always equals PC.
REQ-012 imem_ready_i  input  1  imem_rdata_i valid for current imem_addr_o.
REQ-013 imem_rdata_i  input  32  fetched instruction.
REQ-014 if_id_pc4_o  output  32  registered PC+4 of the instruction in IF/ID.
REQ-015 if_id_inst_o  output  32  registered instruction to decode/Control.
REQ-016 if_id_valid_o  output  1  IF/ID holds a real instruction.

Function
REQ-017 States IDLE, FETCH, HELD; 2-bit state register.
REQ-018 IDLE: imem_req_o=0; start_i=1 -> FETCH next cycle; all other inputs ignored.
REQ-019 FETCH: imem_req_o=1; addr=PC; wait any number of cycles for imem_ready_i.
REQ-020 FETCH, ready=1, stall=0, no redirect: IF/ID <= {PC+4, rdata, valid=1}; PC <= PC+4; stay FETCH; one instruction per cycle at full rate.
REQ-021 FETCH, ready=1, stall=1: capture rdata and PC+4 into a one-entry hold buffer; IF/ID unchanged; PC unchanged; -> HELD.
REQ-022 FETCH, ready=0, stall=0, no redirect: IF/ID valid <= 0 (bubble); PC unchanged.
REQ-023 FETCH, ready=0, stall=1: IF/ID unchanged.
REQ-024 HELD: imem_req_o=0; while stall=1 nothing changes; stall=0 with no redirect -> IF/ID <= hold buffer with valid=1, PC <= PC+4, -> FETCH.
REQ-025 Redirect = (jump_i | branch_i) & ~stall_i; stall_i always wins over redirect.
REQ-026 On redirect in FETCH or HELD: PC <= jump_target_i if jump_i else branch_target_i (jump priority); IF/ID <= {0, 32'h0, valid=0} (flush to NOP); hold buffer discarded; any imem data that cycle discarded; -> FETCH.
REQ-027 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 without error.
REQ-028 PC bits [1:0] carried as given; no alignment check.
REQ-029 No combinational path from any input to if_id_* outputs; imem_req_o/imem_addr_o depend only on state and PC.

Reset
REQ-030 rst_i=1 at a clock edge, in any state: state=IDLE, PC=RESET_PC, imem_req_o=0, if_id_pc4_o=0, if_id_inst_o=0, if_id_valid_o=0, hold buffer cleared; reset overrides start_i, stall_i, redirects and imem_ready_i.
REQ-031 Reset mid-fetch drops the outstanding request; the next fetch after start_i is from RESET_PC.

Configuration
REQ-032 Macro IF_PERF_CNT_EN defined: outputs fetch_cnt_o[31:0] (increments on each IF/ID load with valid=1) and flush_cnt_o[15:0] (increments on each redirect), both saturating, cleared by reset.
REQ-033 Macro IF_PERF_CNT_EN undefined: those ports and counters are absent; all other behaviour identical.

Verification
REQ-034 Reset, start_i pulse, memory ready every cycle with rdata=addr -> IF/ID inst 0,4,8,C in consecutive cycles, pc4 = inst+4, valid=1.
REQ-035 ready=0 for 3 cycles at PC=8 -> addr held 8, three bubbles (valid=0), then inst 8 loaded, PC=C.
REQ-036 stall_i=1 for 2 cycles as ready returns inst at PC=10 -> HELD, req=0, IF/ID unchanged; on release IF/ID=inst@10, PC=14, FETCH.
REQ-037 branch_i=1, target=40 while at PC=20 -> next cycle addr=40, IF/ID valid=0, inst=0; jump_i and branch_i together with targets 80/40 -> PC=80; branch_i with stall_i=1 -> ignored.
REQ-038 rst_i asserted in HELD and at PC=FFFF_FFFC -> IDLE, PC=RESET_PC, all outputs 0; separate run wraps FFFF_FFFC to 0; with IF_PERF_CNT_EN, counters match loads/redirects.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem request and IF/ID pipeline register.
// One-entry hold buffer parks a fetched instruction while decode stalls.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/flush counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_inst_o,
    output logic        if_id_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StHeld} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        redirect;
    logic        fetch_ev;
    logic        flush_ev;

    // Next-state logic: stall beats redirect, redirect beats any imem data.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        hold_pc4_d    = hold_pc4_q;
        hold_inst_d   = hold_inst_q;
        fetch_ev      = 1'b0;
        flush_ev      = 1'b0;
        pc_plus4      = pc_q + 32'd4;
        redirect      = (jump_i | branch_i) & ~stall_i;
        redirect_pc   = jump_i ? jump_target_i : branch_target_i;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (redirect) begin
                    pc_d          = redirect_pc;
                    if_id_pc4_d   = 32'h0;
                    if_id_inst_d  = 32'h0;
                    if_id_valid_d = 1'b0;
                    hold_pc4_d    = 32'h0;
                    hold_inst_d   = 32'h0;
                    flush_ev      = 1'b1;
                end else if (imem_ready_i && !stall_i) begin
                    pc_d          = pc_plus4;
                    if_id_pc4_d   = pc_plus4;
                    if_id_inst_d  = imem_rdata_i;
                    if_id_valid_d = 1'b1;
                    fetch_ev      = 1'b1;
                end else if (imem_ready_i) begin
                    // Decode is stalled: park the word so imem need not repeat it.
                    hold_pc4_d  = pc_plus4;
                    hold_inst_d = imem_rdata_i;
                    state_d     = StHeld;
                end else if (!stall_i) begin
                    if_id_valid_d = 1'b0;
                end
            end
            StHeld: begin
                if (redirect) begin
                    pc_d          = redirect_pc;
                    if_id_pc4_d   = 32'h0;
                    if_id_inst_d  = 32'h0;
                    if_id_valid_d = 1'b0;
                    hold_pc4_d    = 32'h0;
                    hold_inst_d   = 32'h0;
                    flush_ev      = 1'b1;
                    state_d       = StFetch;
                end else if (!stall_i) begin
                    pc_d          = pc_plus4;
                    if_id_pc4_d   = hold_pc4_q;
                    if_id_inst_d  = hold_inst_q;
                    if_id_valid_d = 1'b1;
                    fetch_ev      = 1'b1;
                    state_d       = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, PC, IF/ID and hold buffer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            if_id_pc4_q   <= 32'h0;
            if_id_inst_q  <= 32'h0;
            if_id_valid_q <= 1'b0;
            hold_pc4_q    <= 32'h0;
            hold_inst_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            hold_pc4_q    <= hold_pc4_d;
            hold_inst_q   <= hold_inst_d;
        end
    end

    assign imem_req_o    = (state_q == StFetch);
    assign imem_addr_o   = pc_q;
    assign if_id_pc4_o   = if_id_pc4_q;
    assign if_id_inst_o  = if_id_inst_q;
    assign if_id_valid_o = if_id_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating performance counters for valid IF/ID loads and redirects.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q <= 32'h0;
            flush_cnt_q <= 16'h0;
        end else begin
            if (fetch_ev && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (flush_ev && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    logic unused_ev;
    assign unused_ev = fetch_ev ^ flush_ev;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, start, stall, branch, jump, ready;
    logic [31:0] bt, jt, salt;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_pc4, if_id_inst;
    logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model: running flag, pending-hold flag, PC and the IF/ID contents.
    bit          m_run, m_hold;
    logic [31:0] m_pc, m_pc4, m_inst, m_hold_inst;
    bit          m_valid;
    longint      m_fetch, m_flush;

    always #5 clk = ~clk;

    // Memory returns a scrambled address; garbage while not ready.
    assign imem_rdata = ready ? (imem_addr ^ salt) : 32'hDEAD_BEEF;

    if_stage #(
        .RESET_PC(RST_PC)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .stall_i        (stall),
        .branch_i       (branch),
        .branch_target_i(bt),
        .jump_i         (jump),
        .jump_target_i  (jt),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ready_i   (ready),
        .imem_rdata_i   (imem_rdata),
        .if_id_pc4_o    (if_id_pc4),
        .if_id_inst_o   (if_id_inst),
        .if_id_valid_o  (if_id_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o    (fetch_cnt),
        .flush_cnt_o    (flush_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    task automatic model_step();
        bit redir;
        if (rst) begin
            m_run = 0; m_hold = 0; m_pc = RST_PC; m_pc4 = 0; m_inst = 0; m_valid = 0;
            m_fetch = 0; m_flush = 0;
        end else if (!m_run) begin
            if (start) m_run = 1;
        end else begin
            redir = (jump || branch) && !stall;
            if (redir) begin
                m_pc = jump ? jt : bt;
                m_pc4 = 0; m_inst = 0; m_valid = 0; m_hold = 0;
                if (m_flush < 65535) m_flush++;
            end else if (m_hold) begin
                if (!stall) begin
                    m_inst = m_hold_inst; m_pc4 = m_pc + 32'd4; m_valid = 1;
                    m_pc = m_pc + 32'd4; m_hold = 0;
                    if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
                end
            end else if (ready) begin
                if (stall) begin
                    m_hold = 1; m_hold_inst = mem_word(m_pc);
                end else begin
                    m_inst = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
                    m_pc = m_pc + 32'd4;
                    if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
                end
            end else if (!stall) begin
                m_valid = 0;
            end
        end
    endtask

    // Advance one clock; model sees the same inputs the DUT samples.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; start = 0; stall = 0; branch = 0; jump = 0; ready = 0; bt = 0; jt = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic run_to(input int n);
        start = 1; cycle(); start = 0; ready = 1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; start = 1; stall = 1; branch = 1; jump = 1; ready = 1; jt = 32'h100;
        cycle(); cycle();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (imem_addr !== RST_PC) begin bad++; $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC); end
        total++; if ({if_id_pc4, if_id_inst, if_id_valid} !== 65'h0) begin
            bad++; $display("FAIL rst_ifid: got %h %h %b want 0", if_id_pc4, if_id_inst, if_id_valid);
        end
        clear_inputs();
        ready = 1; branch = 1; stall = 1; bt = 32'h40;
        cycle(); cycle();
        total++; if (imem_req !== 1'b0 || imem_addr !== RST_PC || if_id_valid !== 1'b0) begin
            bad++; $display("FAIL idle_ignore: got req=%b addr=%h v=%b want 0/%h/0", imem_req, imem_addr, if_id_valid, RST_PC);
        end
        clear_inputs();
    endtask

    task automatic test_sequential();
        do_reset();
        start = 1; cycle(); start = 0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL seq_first: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        ready = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            total++; if (if_id_inst !== 32'(4 * i) || if_id_pc4 !== 32'(4 * i + 4) || if_id_valid !== 1'b1) begin
                bad++; $display("FAIL seq_load%0d: got %h/%h/%b want %h/%h/1", i, if_id_inst, if_id_pc4,
                                if_id_valid, 4 * i, 4 * i + 4);
            end
        end
    endtask

    task automatic test_wait();
        do_reset();
        run_to(2);
        ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if (imem_addr !== 32'h8 || if_id_valid !== 1'b0 || imem_req !== 1'b1) begin
                bad++; $display("FAIL wait_bubble%0d: got addr=%h v=%b req=%b want 8/0/1", i, imem_addr, if_id_valid, imem_req);
            end
        end
        ready = 1; cycle();
        total++; if (if_id_inst !== 32'h8 || if_id_valid !== 1'b1 || imem_addr !== 32'hC) begin
            bad++; $display("FAIL wait_resume: got inst=%h v=%b addr=%h want 8/1/c", if_id_inst, if_id_valid, imem_addr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        run_to(4);
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            total++; if (imem_req !== 1'b0 || if_id_inst !== 32'hC || if_id_pc4 !== 32'h10 || if_id_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d: got req=%b inst=%h pc4=%h v=%b want 0/c/10/1", i, imem_req,
                                if_id_inst, if_id_pc4, if_id_valid);
            end
        end
        stall = 0; ready = 0; cycle();
        total++; if (if_id_inst !== 32'h10 || if_id_pc4 !== 32'h14 || imem_addr !== 32'h14 || imem_req !== 1'b1) begin
            bad++; $display("FAIL stall_release: got inst=%h pc4=%h addr=%h req=%b want 10/14/14/1", if_id_inst,
                            if_id_pc4, imem_addr, imem_req);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        run_to(8);
        branch = 1; bt = 32'h40; cycle(); branch = 0;
        total++; if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_inst !== 32'h0 || if_id_pc4 !== 32'h0) begin
            bad++; $display("FAIL branch_flush: got addr=%h v=%b inst=%h pc4=%h want 40/0/0/0", imem_addr, if_id_valid,
                            if_id_inst, if_id_pc4);
        end
        jump = 1; branch = 1; jt = 32'h80; bt = 32'h40; cycle(); jump = 0; branch = 0;
        total++; if (imem_addr !== 32'h80 || if_id_valid !== 1'b0) begin
            bad++; $display("FAIL jump_prio: got addr=%h v=%b want 80/0", imem_addr, if_id_valid);
        end
        branch = 1; stall = 1; bt = 32'h200; cycle();
        total++; if (imem_addr !== 32'h80 || imem_req !== 1'b0) begin
            bad++; $display("FAIL stall_beats_branch: got addr=%h req=%b want 80/0", imem_addr, imem_req);
        end
        branch = 0; stall = 0; cycle();
        total++; if (if_id_inst !== 32'h80 || if_id_valid !== 1'b1 || imem_addr !== 32'h84) begin
            bad++; $display("FAIL after_stall_branch: got inst=%h v=%b addr=%h want 80/1/84", if_id_inst,
                            if_id_valid, imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_to(1);
        stall = 1; cycle();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL enter_held: got req=%b want 0", imem_req); end
        rst = 1; cycle(); rst = 0; stall = 0; ready = 0;
        total++; if (imem_req !== 1'b0 || imem_addr !== RST_PC || if_id_valid !== 1'b0 || if_id_inst !== 32'h0
                     || if_id_pc4 !== 32'h0) begin
            bad++; $display("FAIL rst_in_held: got req=%b addr=%h v=%b inst=%h pc4=%h want all 0", imem_req,
                            imem_addr, if_id_valid, if_id_inst, if_id_pc4);
        end
        start = 1; cycle(); start = 0;
        total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            bad++; $display("FAIL restart_pc: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC);
        end
        jump = 1; jt = 32'hFFFF_FFFC; cycle(); jump = 0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL jump_top: got %h want fffffffc", imem_addr); end
        ready = 1; cycle();
        total++; if (if_id_inst !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap: got inst=%h pc4=%h addr=%h want fffffffc/0/0", if_id_inst, if_id_pc4, imem_addr);
        end
        jump = 1; cycle(); jump = 0; ready = 0;
        rst = 1; cycle(); rst = 0;
        total++; if (imem_req !== 1'b0 || imem_addr !== RST_PC || if_id_valid !== 1'b0) begin
            bad++; $display("FAIL rst_at_top: got req=%b addr=%h v=%b want 0/%h/0", imem_req, imem_addr, if_id_valid, RST_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        salt = $urandom;
        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 79) == 0);
            start  = ($urandom_range(0, 3) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            ready  = ($urandom_range(0, 3) != 0);
            branch = ($urandom_range(0, 7) == 0);
            jump   = ($urandom_range(0, 9) == 0);
            bt     = $urandom;
            jt     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
            cycle();
            total++; if (imem_req !== (m_run && !m_hold)) begin
                bad++; $display("FAIL rnd_req@%0d: got %b want %b", i, imem_req, m_run && !m_hold);
            end
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr@%0d: got %h want %h", i, imem_addr, m_pc); end
            total++; if (if_id_valid !== m_valid) begin
                bad++; $display("FAIL rnd_valid@%0d: got %b want %b", i, if_id_valid, m_valid);
            end
            total++; if (if_id_inst !== m_inst || if_id_pc4 !== m_pc4) begin
                bad++; $display("FAIL rnd_ifid@%0d: got %h/%h want %h/%h", i, if_id_inst, if_id_pc4, m_inst, m_pc4);
            end
`ifdef IF_PERF_CNT_EN
            total++; if (fetch_cnt !== 32'(m_fetch) || flush_cnt !== 16'(m_flush)) begin
                bad++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", i, fetch_cnt, flush_cnt, m_fetch, m_flush);
            end
`endif
        end
        clear_inputs();
    endtask

    initial begin
        salt = 32'h0;
        clear_inputs();
        rst = 1;
        test_reset();
        test_sequential();
        test_wait();
        test_stall();
        test_redirect();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
